// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
//   fp_class_e      : operand class used by the special-case resolver
//   bias()          : exponent bias for a given exponent width
//   sig_w()/ext_w() : significand width (hidden bit included) and the
//                     extended add width (carry + significand + G/R/S)
// fp_unpacked_t {sign, exp, sig, cls} is declared inside fp_add_pipe, sized
// with sig_w(), because a package typedef cannot follow module parameters.
package fp_pkg;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int sig_w(input int man_w);
    return man_w + 1;
  endfunction

  function automatic int ext_w(input int man_w);
    return man_w + 5;
  endfunction

  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic man_zero);
    if (exp_ones)      return man_zero ? INF : NAN;
    else if (exp_zero) return man_zero ? ZERO : SUB;
    else               return NORM;
  endfunction

endpackage

// File: rtl/fp_add_pipe_if.sv
// Operand / result handshake bundle for fp_add_pipe.
//   in_valid/in_ready  : operand handshake (a, b, sub)
//   out_valid/out_ready: result handshake (sum[, out_flags])
// master = issuing/consuming side, slave = the adder.
// FP_ADD_FLAGS_EN adds out_flags {invalid, overflow, inexact}.
interface fp_add_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid, in_ready, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] a, b, sum;
`ifdef FP_ADD_FLAGS_EN
  logic [2:0]       out_flags;
`endif

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum
`ifdef FP_ADD_FLAGS_EN
    , out_flags
`endif
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum
`ifdef FP_ADD_FLAGS_EN
    , out_flags
`endif
  );
endinterface

// File: rtl/fp_norm_round.sv
// Combinational normalise + round stage of fp_add_pipe.
//   mag   : aligned sum/difference {carry, hidden, mantissa, G, R, S}
//   exp   : biased exponent of the larger operand (>= 1)
//   sign  : result sign for a non-zero result
//   zsign : sign to use when the magnitude cancelled to exactly zero
//   res   : packed result {sign, exp, mantissa}
//   ovf, inexact (FP_ADD_FLAGS_EN only): overflow to inf, any bits lost
module fp_norm_round #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic [MAN_W+4:0]       mag,
  input  logic [EXP_W-1:0]       exp,
  input  logic                   sign,
  input  logic                   zsign,
  output logic [EXP_W+MAN_W:0]   res
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic                   ovf,
  output logic                   inexact
`endif
);
  localparam int XW = MAN_W + 5;   // carry + hidden + mantissa + G/R/S
  localparam int NW = MAN_W + 4;   // after carry handling: hidden + mantissa + G/R/S
  localparam int EW = EXP_W + 1;   // one spare bit to see overflow
  localparam int W  = 1 + EXP_W + MAN_W;

  logic [NW-1:0]      n;
  logic [EW-1:0]      e;
  logic [MAN_W+1:0]   rnd;
  logic [MAN_W-1:0]   man;
  logic               inc, hid, of;
  int                 lz, sh, lim;

  always_comb begin
    n   = '0;
    e   = '0;
    rnd = '0;
    man = '0;
    inc = 1'b0;
    hid = 1'b0;
    of  = 1'b0;
    lz  = NW;
    sh  = 0;
    lim = 0;
    res = '0;

    // highest set bit wins: ascending scan, last hit overwrites
    for (int i = 0; i < NW; i++)
      if (mag[i]) lz = NW - 1 - i;

    if (mag[XW-1]) begin
      // carry out: drop one bit into the sticky position
      n = {mag[XW-1:2], mag[1] | mag[0]};
      e = {1'b0, exp} + EW'(1);
    end else begin
      // never shift the exponent below 1; what remains is a subnormal
      lim = int'(exp) - 1;
      sh  = (lz < lim) ? lz : lim;
      n   = mag[NW-1:0] << sh;
      e   = {1'b0, exp} - EW'(sh);
    end

    // round to nearest, ties to even
    inc = n[2] & (n[1] | n[0] | n[3]);
    rnd = {1'b0, n[NW-1:3]} + (MAN_W+2)'(inc);
    if (rnd[MAN_W+1]) begin
      e   = e + EW'(1);
      hid = 1'b1;
      man = '0;
    end else begin
      hid = rnd[MAN_W];
      man = rnd[MAN_W-1:0];
    end

    of = (e >= EW'((1 << EXP_W) - 1));

    if (mag == '0)
      res = {zsign, {(W-1){1'b0}}};
    else if (of)
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      res = {sign, hid ? e[EXP_W-1:0] : {EXP_W{1'b0}}, man};
  end

`ifdef FP_ADD_FLAGS_EN
  assign ovf     = of && (mag != '0);
  assign inexact = (|n[2:0]) | ovf;
`endif

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined floating-point adder/subtractor.
//   S1: unpack, classify, resolve specials, order operands by magnitude
//   S2: align smaller operand (G/R/S kept), add or subtract magnitudes
//   S3: normalise + round (fp_norm_round), registered onto sum
// Ports: clk, rst_n (async, active low), io (fp_add_pipe_if.slave).
// Global stall: every stage freezes while a result waits on out_ready.
// Optional: FP_ADD_FLAGS_EN adds io.out_flags {invalid, overflow, inexact}.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_add_pipe_if.slave io
);
  localparam int SW    = sig_w(MAN_W);
  localparam int XW    = ext_w(MAN_W);
  localparam int BW    = XW - 1;
  localparam int SHMAX = MAN_W + 3;

  if (WIDTH != 1 + EXP_W + MAN_W) begin : g_width_chk
    $error("fp_add_pipe: WIDTH must equal 1+EXP_W+MAN_W");
  end

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;   // biased; subnormals read as 1
    logic [SW-1:0]    sig;   // hidden bit included
    fp_class_e        cls;
  } fp_unpacked_t;

  typedef struct packed {
    logic             spec;
    logic [WIDTH-1:0] res;
`ifdef FP_ADD_FLAGS_EN
    logic             inv;
`endif
    logic             sign, zsign, sub;
    logic [EXP_W-1:0] exp, diff;
    logic [SW-1:0]    siga, sigb;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [WIDTH-1:0] res;
`ifdef FP_ADD_FLAGS_EN
    logic             inv;
`endif
    logic             sign, zsign;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    mag;
  } s2_t;

  function automatic fp_unpacked_t unpack(input logic [WIDTH-1:0] x, input logic flip);
    fp_unpacked_t u;
    logic e0, e1, m0;
    e0    = (x[WIDTH-2 -: EXP_W] == '0);
    e1    = (x[WIDTH-2 -: EXP_W] == '1);
    m0    = (x[MAN_W-1:0] == '0);
    u.sign = x[WIDTH-1] ^ flip;
    u.exp  = e0 ? EXP_W'(1) : x[WIDTH-2 -: EXP_W];
    u.sig  = {~e0, x[MAN_W-1:0]};
    u.cls  = classify(e0, e1, m0);
    return u;
  endfunction

  logic [3:1]       vld_pipe;
  logic             adv;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [WIDTH-1:0] nr_res, sum_d, sum_q;
`ifdef FP_ADD_FLAGS_EN
  logic             nr_ovf, nr_inx;
  logic [2:0]       flags_d, flags_q;
`endif

  assign adv          = !vld_pipe[3] || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe[3];
  assign io.sum       = sum_q;
`ifdef FP_ADD_FLAGS_EN
  assign io.out_flags = flags_q;
`endif

  // ---------------- S1 ----------------
  fp_unpacked_t ua, ub;
  logic         a_ge;

  always_comb begin
    ua   = unpack(io.a, 1'b0);
    ub   = unpack(io.b, io.sub);
    // magnitude order equals the order of the raw {exp, man} bits
    a_ge = (io.a[WIDTH-2:0] >= io.b[WIDTH-2:0]);

    s1_d       = '0;
    s1_d.sub   = ua.sign ^ ub.sign;
    s1_d.zsign = ua.sign & ub.sign;   // only like-signed zeros keep a minus
    s1_d.sign  = a_ge ? ua.sign : ub.sign;
    s1_d.exp   = a_ge ? ua.exp : ub.exp;
    s1_d.diff  = a_ge ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
    s1_d.siga  = a_ge ? ua.sig : ub.sig;
    s1_d.sigb  = a_ge ? ub.sig : ua.sig;

    s1_d.spec = 1'b1;
    if (ua.cls == NAN)
      s1_d.res = io.a;
    else if (ub.cls == NAN)
      s1_d.res = io.b;
    else if (ua.cls == INF && ub.cls == INF && s1_d.sub) begin
      s1_d.res = {io.a[WIDTH-1], {(WIDTH-1){1'b1}}};
`ifdef FP_ADD_FLAGS_EN
      s1_d.inv = 1'b1;
`endif
    end else if (ua.cls == INF)
      s1_d.res = io.a;
    else if (ub.cls == INF)
      s1_d.res = {ub.sign, io.b[WIDTH-2:0]};
    else
      s1_d.spec = 1'b0;
  end

  // ---------------- S2 ----------------
  int unsigned   shamt;
  logic [BW-1:0] b_ext, b_al;
  logic          sticky;

  always_comb begin
    shamt  = 32'(s1_q.diff);
    if (shamt > SHMAX) shamt = SHMAX;
    b_ext  = {s1_q.sigb, 3'b000};
    sticky = |(b_ext & ~({BW{1'b1}} << shamt));
    b_al   = (b_ext >> shamt) | BW'(sticky);

    s2_d       = '0;
    s2_d.spec  = s1_q.spec;
    s2_d.res   = s1_q.res;
`ifdef FP_ADD_FLAGS_EN
    s2_d.inv   = s1_q.inv;
`endif
    s2_d.sign  = s1_q.sign;
    s2_d.zsign = s1_q.zsign;
    s2_d.exp   = s1_q.exp;
    // |A| >= |B| so the difference never goes negative
    s2_d.mag   = s1_q.sub ? ({1'b0, s1_q.siga, 3'b000} - {1'b0, b_al})
                          : ({1'b0, s1_q.siga, 3'b000} + {1'b0, b_al});
  end

  // ---------------- S3 ----------------
  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_nr (
    .mag     (s2_q.mag),
    .exp     (s2_q.exp),
    .sign    (s2_q.sign),
    .zsign   (s2_q.zsign),
    .res     (nr_res)
`ifdef FP_ADD_FLAGS_EN
    ,
    .ovf     (nr_ovf),
    .inexact (nr_inx)
`endif
  );

  assign sum_d = s2_q.spec ? s2_q.res : nr_res;
`ifdef FP_ADD_FLAGS_EN
  assign flags_d = s2_q.spec ? {s2_q.inv, 2'b00} : {1'b0, nr_ovf, nr_inx};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      sum_q    <= '0;
`ifdef FP_ADD_FLAGS_EN
      flags_q  <= '0;
`endif
    end else if (adv) begin
      vld_pipe <= {vld_pipe[2:1], io.in_valid};
      if (io.in_valid) s1_q <= s1_d;
      if (vld_pipe[1]) s2_q <= s2_d;
      if (vld_pipe[2]) begin
        sum_q   <= sum_d;
`ifdef FP_ADD_FLAGS_EN
        flags_q <= flags_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe (8-bit: EXP_W=4, MAN_W=3, bias 7).
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.WIDTH(8)) io ();
  fp_add_pipe #(.EXP_W(4), .MAN_W(3), .WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] exp;
    logic [2:0] flg;   // {invalid, overflow, inexact}
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];
  int checks = 0;
  int fails  = 0;
  logic [7:0] got [$];
`ifdef FP_ADD_FLAGS_EN
  logic [2:0] gotf [$];
`endif
  int   idx;
  logic acc;

  always @(negedge clk)
    if (rst_n && io.out_valid && io.out_ready) begin
      got.push_back(io.sum);
`ifdef FP_ADD_FLAGS_EN
      gotf.push_back(io.out_flags);
`endif
    end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    io.a = v.a; io.b = v.b; io.sub = v.sub; io.in_valid = 1'b1;
  endtask

  task automatic wait_got(input int n);
    for (int c = 0; c < 60 && got.size() < n; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("result_count", got.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv = '{
      '{8'h38, 8'h38, 1'b0, 8'h40, 3'b000},  // 1+1
      '{8'h40, 8'h3F, 1'b1, 8'h20, 3'b000},  // 2-1.875, deep normalise
      '{8'h38, 8'h18, 1'b0, 8'h38, 3'b001},  // tie, even stays
      '{8'h39, 8'h18, 1'b0, 8'h3A, 3'b001},  // tie, odd rounds up
      '{8'hC0, 8'h38, 1'b0, 8'hB8, 3'b000},  // -2+1
      '{8'h38, 8'h38, 1'b1, 8'h00, 3'b000},  // cancel -> +0
      '{8'h80, 8'h00, 1'b1, 8'h80, 3'b000},  // -0 - +0
      '{8'h80, 8'h80, 1'b0, 8'h80, 3'b000},  // -0 + -0
      '{8'h00, 8'h80, 1'b0, 8'h00, 3'b000},  // +0 + -0
      '{8'h77, 8'h77, 1'b0, 8'h78, 3'b011},  // overflow (always inexact)
      '{8'h01, 8'h01, 1'b0, 8'h02, 3'b000},  // subnormal
      '{8'h78, 8'h78, 1'b1, 8'h7F, 3'b100},  // inf-inf
      '{8'h79, 8'h38, 1'b0, 8'h79, 3'b000},  // a NaN
      '{8'h38, 8'hF9, 1'b1, 8'hF9, 3'b000},  // b NaN, not sign flipped
      '{8'h78, 8'hF8, 1'b0, 8'h7F, 3'b100},  // +inf + -inf
      '{8'hF8, 8'h78, 1'b0, 8'hFF, 3'b100},  // -inf + +inf
      '{8'h38, 8'h78, 1'b1, 8'hF8, 3'b000},  // 1 - inf
      '{8'h78, 8'h38, 1'b1, 8'h78, 3'b000},  // inf - 1
      '{8'h3F, 8'h18, 1'b0, 8'h40, 3'b001},  // round carry into exponent
      '{8'h77, 8'h50, 1'b0, 8'h78, 3'b011},  // rounding overflows
      '{8'h76, 8'h50, 1'b0, 8'h76, 3'b001},  // tie at max range, even
      '{8'h08, 8'h01, 1'b1, 8'h07, 3'b000},  // normal - sub -> subnormal
      '{8'h38, 8'h01, 1'b0, 8'h38, 3'b001},  // saturated shift, sticky only
      '{8'h38, 8'h19, 1'b0, 8'h39, 3'b001},  // above tie via sticky
      '{8'h38, 8'hC0, 1'b0, 8'hB8, 3'b000},  // swap path
      '{8'h70, 8'h00, 1'b0, 8'h70, 3'b000},  // x + 0
      '{8'h0F, 8'h01, 1'b0, 8'h10, 3'b000},  // sub carry -> exp 2
      '{8'h07, 8'h01, 1'b0, 8'h08, 3'b000}   // sub + sub -> min normal
    };

    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.sub = 1'b0; io.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", io.out_valid, 0);
    check("rst_sum", io.sum, 8'h00);
    check("rst_in_ready", io.in_ready, 1);
`ifdef FP_ADD_FLAGS_EN
    check("rst_flags", io.out_flags, 3'b000);
`endif
    rst_n = 1'b1;

    // latency: accepted at edge 1, visible after edge 3
    @(posedge clk); #1;
    drive(tv[0]);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    check("lat_edge1_valid", io.out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", io.out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge3_valid", io.out_valid, 1);
    check("lat_sum", io.sum, 8'h40);
    repeat (2) @(posedge clk);
    #1;
    got.delete();
`ifdef FP_ADD_FLAGS_EN
    gotf.delete();
`endif

    // table, streamed back to back
    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    wait_got(NV);
    for (int i = 0; i < NV && i < got.size(); i++) begin
      check($sformatf("vec%0d_sum", i), got[i], tv[i].exp);
`ifdef FP_ADD_FLAGS_EN
      check($sformatf("vec%0d_flags", i), gotf[i], tv[i].flg);
`endif
    end

    // backpressure: out_ready low in cycles 4..6 of a 5-op stream
    got.delete();
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      io.out_ready = !(cyc >= 4 && cyc <= 6);
      if (idx < 5) drive(tv[idx]);
      else io.in_valid = 1'b0;
      @(negedge clk);
      if (cyc >= 4 && cyc <= 6) begin
        check($sformatf("bp_c%0d_in_ready", cyc), io.in_ready, 0);
        check($sformatf("bp_c%0d_out_valid", cyc), io.out_valid, 1);
        check($sformatf("bp_c%0d_sum_hold", cyc), io.sum, tv[1].exp);
      end
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    wait_got(5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("bp_order%0d", i), got[i], tv[i].exp);

    // reset with three ops in flight
    got.delete();
    for (int i = 0; i < 3; i++) begin
      drive(tv[i + 2]);
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    #1;
    check("rstmid_pre_valid", io.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", io.out_valid, 0);
    check("rstmid_sum", io.sum, 8'h00);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rstmid_no_results", got.size(), 0);
    check("rstmid_idle_valid", io.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
